// File: rtl/bus_pkg.sv
// Shared types and constants for the core data-bus controller.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAM_WAIT,
        MMIO_WAIT,
        RESP
    } bus_state_e;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    // True when addr falls inside the 2^aw-byte window starting at the aligned base.
    function automatic logic in_window(logic [31:0] addr, logic [31:0] base, int unsigned aw);
        logic [31:0] hi_mask;
        hi_mask = ~((32'd1 << aw) - 32'd1);
        return (addr & hi_mask) == base;
    endfunction

endpackage

// File: rtl/addr_decode.sv
// Combinational address decoder: maps a byte address to SRAM, MMIO or unmapped.
module addr_decode
    import bus_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter int unsigned RAM_AW    = 14,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter int unsigned MMIO_AW   = 12
) (
    input  logic [31:0] addr_i,
    output region_e     region_o
);

    // SRAM is checked first so it wins if the windows overlap.
    always_comb begin
        region_o = REG_NONE;
        if (in_window(addr_i, RAM_BASE, RAM_AW)) begin
            region_o = REG_RAM;
        end else if (in_window(addr_i, MMIO_BASE, MMIO_AW)) begin
            region_o = REG_MMIO;
        end
    end

endmodule

// File: rtl/data_bus_ctrl.sv
// Routes single core load/store accesses to data SRAM or the accelerator MMIO window,
// completing every access (including unmapped and timed-out ones) with a one-cycle core_valid.
module data_bus_ctrl
    import bus_pkg::*;
#(
    parameter logic [31:0] RAM_BASE     = 32'h0000_0000,
    parameter int unsigned RAM_AW       = 14,
    parameter int unsigned RAM_RD_LAT   = 1,
    parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
    parameter int unsigned MMIO_AW      = 12,
    parameter int unsigned MMIO_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_cs,
    input  logic                core_rd_wr,
    input  logic [3:0]          core_mask,
    input  logic [31:0]         core_addr,
    input  logic [31:0]         core_wdata,
    output logic [31:0]         core_rdata,
    output logic                core_valid,
    output logic                bus_err,
    output logic                ram_en,
    output logic [3:0]          ram_we,
    output logic [RAM_AW-3:0]   ram_addr,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata,
    output logic                mmio_req,
    output logic                mmio_we,
    output logic [3:0]          mmio_mask,
    output logic [MMIO_AW-1:0]  mmio_addr,
    output logic [31:0]         mmio_wdata,
    input  logic [31:0]         mmio_rdata,
    input  logic                mmio_ack
);

    localparam int unsigned CntMax = (MMIO_TIMEOUT > RAM_RD_LAT) ? MMIO_TIMEOUT : RAM_RD_LAT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    bus_state_e         state_q, state_d;
    logic [MMIO_AW-1:0] addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         mask_q, mask_d;
    logic               rd_q, rd_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    region_e            region;

    addr_decode #(
        .RAM_BASE  (RAM_BASE),
        .RAM_AW    (RAM_AW),
        .MMIO_BASE (MMIO_BASE),
        .MMIO_AW   (MMIO_AW)
    ) u_addr_decode (
        .addr_i   (core_addr),
        .region_o (region)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rd_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        rd_d      = rd_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        ram_en    = 1'b0;
        ram_we    = 4'b0;
        ram_addr  = '0;
        ram_wdata = '0;

        unique case (state_q)
            IDLE: begin
                // Gating on reset keeps the SRAM strobe quiet while the block is held in reset.
                if (core_cs && reset) begin
                    addr_d  = core_addr[MMIO_AW-1:0];
                    wdata_d = core_wdata;
                    mask_d  = core_mask;
                    rd_d    = core_rd_wr;
                    cnt_d   = '0;
                    unique case (region)
                        REG_RAM: begin
                            ram_en    = 1'b1;
                            ram_we    = core_rd_wr ? 4'b0 : core_mask;
                            ram_addr  = core_addr[RAM_AW-1:2];
                            ram_wdata = core_wdata;
                            if (core_rd_wr) begin
                                state_d = RAM_WAIT;
                            end else begin
                                rdata_d = '0;
                                err_d   = 1'b0;
                                state_d = RESP;
                            end
                        end
                        REG_MMIO: begin
                            state_d = MMIO_WAIT;
                        end
                        default: begin
                            rdata_d = BUS_ERR_DATA;
                            err_d   = 1'b1;
                            state_d = RESP;
                        end
                    endcase
                end
            end
            RAM_WAIT: begin
                if (cnt_q == CntW'(RAM_RD_LAT - 1)) begin
                    rdata_d = ram_rdata;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            MMIO_WAIT: begin
                // An ack arriving in the final allowed cycle still completes normally.
                if (mmio_ack) begin
                    rdata_d = rd_q ? mmio_rdata : 32'h0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == CntW'(MMIO_TIMEOUT - 1)) begin
                    rdata_d = BUS_ERR_DATA;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        core_valid = (state_q == RESP);
        core_rdata = core_valid ? rdata_q : 32'h0;
        bus_err    = core_valid & err_q;
        mmio_req   = (state_q == MMIO_WAIT);
        mmio_we    = mmio_req & ~rd_q;
        mmio_mask  = mmio_req ? mask_q : 4'b0;
        mmio_addr  = mmio_req ? addr_q : '0;
        mmio_wdata = mmio_req ? wdata_q : 32'h0;
    end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Self-checking bench for data_bus_ctrl: directed corner cases plus randomized accesses
// checked against a transaction-level model of regions, latencies and SRAM contents.
module tb_data_bus_ctrl;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned RD_LAT  = 1;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        core_cs;
    logic        core_rd_wr;
    logic [3:0]  core_mask;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_valid;
    logic        bus_err;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        mmio_req;
    logic        mmio_we;
    logic [3:0]  mmio_mask;
    logic [11:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        mmio_ack;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] sram    [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] rd_pipe;

    data_bus_ctrl #(
        .RAM_BASE     (32'h0000_0000),
        .RAM_AW       (14),
        .RAM_RD_LAT   (RD_LAT),
        .MMIO_BASE    (32'h8000_0000),
        .MMIO_AW      (12),
        .MMIO_TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_cs    (core_cs),
        .core_rd_wr (core_rd_wr),
        .core_mask  (core_mask),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_valid (core_valid),
        .bus_err    (bus_err),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .mmio_req   (mmio_req),
        .mmio_we    (mmio_we),
        .mmio_mask  (mmio_mask),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata),
        .mmio_ack   (mmio_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0013);
    endfunction

    // Behavioural single-port SRAM, one-cycle read latency, refilled while reset is low.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4096; i++) sram[i] <= init_word(i);
        end else if (ram_en) begin
            if (ram_we != 4'b0) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_we[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                rd_pipe <= sram[ram_addr];
            end
        end
    end
    assign ram_rdata = rd_pipe;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_ref();
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    endtask

    // One access, driven in the cycle after the previous completion (back-to-back).
    // ack_at: request cycle (1-based) in which mmio_ack is pulsed; 0 or >TIMEOUT means no ack in time.
    task automatic access(input logic rd, input logic [3:0] mask, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_at, input logic [31:0] mdata);
        int          kind;
        int          lat;
        int          req_cycles;
        logic        err;
        logic [31:0] exp_rd;
        if (addr < 32'h0000_4000) kind = 0;
        else if (addr >= 32'h8000_0000 && addr < 32'h8000_1000) kind = 1;
        else kind = 2;
        req_cycles = 0;
        if (kind == 0) begin
            err    = 1'b0;
            lat    = rd ? int'(RD_LAT) + 1 : 1;
            exp_rd = rd ? ref_mem[addr[13:2]] : 32'h0;
        end else if (kind == 1) begin
            err        = !(ack_at >= 1 && ack_at <= int'(TIMEOUT));
            req_cycles = err ? int'(TIMEOUT) : ack_at;
            lat        = req_cycles + 1;
            exp_rd     = err ? ERR_WORD : (rd ? mdata : 32'h0);
        end else begin
            err    = 1'b1;
            lat    = 1;
            exp_rd = ERR_WORD;
        end

        @(posedge clk); #1;
        core_cs    = 1'b1;
        core_rd_wr = rd;
        core_mask  = mask;
        core_addr  = addr;
        core_wdata = wdata;
        mmio_ack   = 1'b0;
        mmio_rdata = mdata;
        @(negedge clk);
        chk("ram_en", ram_en, kind == 0);
        chk("ram_we", ram_we, (kind == 0 && !rd) ? mask : 4'b0);
        if (kind == 0) chk("ram_addr", ram_addr, addr[13:2]);
        if (kind == 0 && !rd) chk("ram_wdata", ram_wdata, wdata);
        chk("mmio_req_accept", mmio_req, 0);
        chk("valid_accept", core_valid, 0);

        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            mmio_ack = (kind == 1 && c == ack_at);
            @(negedge clk);
            chk("mmio_req", mmio_req, c <= req_cycles);
            if (c == 1 && req_cycles > 0) begin
                chk("mmio_addr", mmio_addr, addr[11:0]);
                chk("mmio_we", mmio_we, !rd);
                chk("mmio_mask", mmio_mask, mask);
                chk("mmio_wdata", mmio_wdata, wdata);
            end
            chk("ram_en_busy", ram_en, 0);
            chk("core_valid", core_valid, c == lat);
        end
        chk("core_rdata", core_rdata, exp_rd);
        chk("bus_err", bus_err, err);

        if (kind == 0 && !rd) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) ref_mem[addr[13:2]][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        core_cs  = 1'b0;
        mmio_ack = 1'b0;
        @(negedge clk);
        chk("idle_valid", core_valid, 0);
        chk("idle_ram_en", ram_en, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        reset      = 1'b0;
        core_cs    = 1'b0;
        core_rd_wr = 1'b0;
        core_mask  = 4'b0;
        core_addr  = 32'h0;
        core_wdata = 32'h0;
        mmio_rdata = 32'h0;
        mmio_ack   = 1'b0;
        reset_ref();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", core_valid, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_rdata", core_rdata, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_mmio_req", mmio_req, 0);
        chk("rst_mmio_addr", mmio_addr, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        access(1'b0, 4'b0011, 32'h0000_0010, 32'hA5A5_1234, 0, 32'h0);
        access(1'b1, 4'b1111, 32'h0000_0010, 32'h0, 0, 32'h0);
        access(1'b1, 4'b1111, 32'h8000_0004, 32'h0, 3, 32'hCAFE_0001);
        access(1'b0, 4'b1010, 32'h8000_0020, 32'h1357_9BDF, 0, 32'h0);
        access(1'b1, 4'b1111, 32'h4000_0000, 32'h0, 0, 32'h0);
        idle_cycle();
        access(1'b0, 4'b1111, 32'h0000_3FFC, 32'h0BAD_F00D, 0, 32'h0);
        access(1'b1, 4'b0000, 32'h0000_3FFC, 32'h0, 0, 32'h0);
        access(1'b1, 4'b1111, 32'h0000_4000, 32'h0, 0, 32'h0);
        access(1'b1, 4'b1111, 32'h8000_0FFC, 32'h0, int'(TIMEOUT), 32'h7777_8888);
        access(1'b1, 4'b1111, 32'h8000_1000, 32'h0, 1, 32'h0);
        access(1'b0, 4'b0001, 32'h8000_0100, 32'h0000_00AA, 1, 32'h1111_2222);
        access(1'b1, 4'b1111, 32'h7FFF_FFFC, 32'h0, 0, 32'h0);
        access(1'b1, 4'b1111, 32'h8000_0040, 32'h0, int'(TIMEOUT) + 1, 32'h3333_4444);

        // Reset while an MMIO request is outstanding.
        @(posedge clk); #1;
        core_cs    = 1'b1;
        core_rd_wr = 1'b1;
        core_addr  = 32'h8000_0008;
        mmio_ack   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_req", mmio_req, 1);
        #2;
        reset   = 1'b0;
        core_cs = 1'b0;
        #1;
        chk("rst_drop_req", mmio_req, 0);
        chk("rst_drop_valid", core_valid, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        reset_ref();
        @(posedge clk); #1;
        mmio_ack   = 1'b1;
        mmio_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("stray_ack_valid", core_valid, 0);
        chk("stray_ack_req", mmio_req, 0);
        idle_cycle();
        access(1'b1, 4'b1111, 32'h8000_0008, 32'h0, 2, 32'h2468_ACE0);
        access(1'b1, 4'b1111, 32'h0000_0010, 32'h0, 0, 32'h0);

        for (int n = 0; n < 80; n++) begin
            k = int'($urandom_range(0, 2));
            if (k == 0) begin
                a = ($urandom_range(0, 3) == 0) ? 32'h0000_3F00 + 32'($urandom_range(0, 255))
                                                 : 32'($urandom_range(0, 255));
            end else if (k == 1) begin
                a = 32'h8000_0000 | 32'($urandom_range(0, 4095));
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 32'h4000_0000 + 32'($urandom_range(0, 4095));
                    1:       a = 32'h0000_4000 + 32'($urandom_range(0, 255));
                    2:       a = 32'h8000_1000 + 32'($urandom_range(0, 255));
                    default: a = 32'hFFFF_FFF0;
                endcase
            end
            access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
                   int'($urandom_range(0, TIMEOUT + 2)), $urandom);
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
